// File: rtl/mesh_audio_sampler.sv
// mesh_audio_sampler: scales mesh samples to saturated 16-bit PCM and buffers them in a FIFO,
// releasing one sample per falling LR-clock edge, with sticky overflow/underflow/clip flags.
module mesh_audio_sampler #(
  parameter int DEPTH = 8,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic [17:0]   iU_MID,
  input  logic          iVALID,
  input  logic          iMUTE,
  input  logic [1:0]    iGAIN,
  input  logic          iLRCK,
  output logic [15:0]   oSAMPLE,
  output logic [LW-1:0] oLEVEL,
  output logic          oOVERFLOW,
  output logic          oUNDERFLOW,
  output logic          oCLIP
);
  localparam int PW = LW - 1;
  logic [15:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [LW-1:0] level_q, level_d;
  logic [15:0] sample_q, scaled;
  logic vld_q, s1_q, s2_q, s3_q, ovf_q, udf_q, clip_q;
  logic signed [20:0] x, y;
  logic sat_hi, sat_lo, full, empty, push, pop, do_push, do_pop;
  always_comb begin
    x = $signed({{3{iU_MID[17]}}, iU_MID}) <<< iGAIN;
    y = x >>> 2;
    sat_hi = y > 21'sd32767;
    sat_lo = y < -21'sd32768;
    scaled = sat_hi ? 16'h7FFF : sat_lo ? 16'h8000 : y[15:0];
    full = level_q == LW'(DEPTH);
    empty = level_q == '0;
    push = iVALID & ~vld_q & ~iMUTE;
    pop = s3_q & ~s2_q & ~iMUTE;
    do_push = push & (~full | pop);
    do_pop = pop & ~empty;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end
  // storage needs no reset: occupancy alone decides what is readable
  always_ff @(posedge iCLK)
    if (do_push) mem_q[wr_q] <= scaled;
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      vld_q <= 1'b0;
      {s1_q, s2_q, s3_q} <= 3'b111;
      rd_q <= '0;
      wr_q <= '0;
      level_q <= '0;
      sample_q <= '0;
      {ovf_q, udf_q, clip_q} <= 3'b000;
    end else begin
      vld_q <= iVALID;
      {s1_q, s2_q, s3_q} <= {iLRCK, s1_q, s2_q};
      if (iMUTE) begin
        rd_q <= '0;
        wr_q <= '0;
        level_q <= '0;
        sample_q <= '0;
        {ovf_q, udf_q, clip_q} <= 3'b000;
      end else begin
        if (do_push) wr_q <= wr_q + PW'(1);
        if (do_pop) begin
          rd_q <= rd_q + PW'(1);
          sample_q <= mem_q[rd_q];
        end
        level_q <= level_d;
        ovf_q <= ovf_q | (push & full & ~pop);
        udf_q <= udf_q | (pop & empty);
        clip_q <= clip_q | (push & (sat_hi | sat_lo));
      end
    end
  assign oSAMPLE = sample_q;
  assign oLEVEL = level_q;
  assign oOVERFLOW = ovf_q;
  assign oUNDERFLOW = udf_q;
  assign oCLIP = clip_q;
endmodule

// File: tb/tb_mesh_audio_sampler.sv
// tb_mesh_audio_sampler: directed and randomized checks of mesh_audio_sampler against a
// queue-based reference model that follows the sampling and FIFO rules directly.
module tb_mesh_audio_sampler;
  localparam int DEPTH = 8;
  localparam int LW = $clog2(DEPTH) + 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [17:0] u_mid = '0;
  logic valid = 1'b0, mute = 1'b0, lrck = 1'b1;
  logic [1:0] gain = '0;
  logic [15:0] o_sample;
  logic [LW-1:0] o_level;
  logic o_ovf, o_udf, o_clip;
  int checks = 0, errors = 0;

  mesh_audio_sampler #(.DEPTH(DEPTH)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iU_MID(u_mid), .iVALID(valid), .iMUTE(mute),
    .iGAIN(gain), .iLRCK(lrck), .oSAMPLE(o_sample), .oLEVEL(o_level),
    .oOVERFLOW(o_ovf), .oUNDERFLOW(o_udf), .oCLIP(o_clip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a sample queue plus the input history the codec-side rules depend on
  logic [15:0] q[$];
  logic [15:0] m_sample = '0;
  bit m_ovf = 0, m_udf = 0, m_clip = 0, v_prev = 0, pu, po;
  bit [2:0] lh = 3'b111;
  int sz, yv;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_sample = '0;
      {m_ovf, m_udf, m_clip} = 3'b000;
      v_prev = 0;
      lh = 3'b111;
    end else begin
      pu = valid && !v_prev;
      po = lh[2] && !lh[1];
      v_prev = valid;
      lh = {lh[1:0], lrck};
      if (mute) begin
        q.delete();
        m_sample = '0;
        {m_ovf, m_udf, m_clip} = 3'b000;
      end else begin
        sz = q.size();
        if (po) begin
          if (sz > 0) m_sample = q.pop_front();
          else m_udf = 1;
        end
        if (pu) begin
          yv = (int'($signed(u_mid)) * (1 << gain)) >>> 2;
          if (yv > 32767 || yv < -32768) m_clip = 1;
          yv = yv > 32767 ? 32767 : yv < -32768 ? -32768 : yv;
          if (sz < DEPTH || po) q.push_back(16'(yv));
          else m_ovf = 1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("model_sample", o_sample, m_sample);
      chk("model_level", o_level, q.size());
      chk("model_ovf", o_ovf, m_ovf);
      chk("model_udf", o_udf, m_udf);
      chk("model_clip", o_clip, m_clip);
    end
  end

  task automatic push(input logic [17:0] u, input logic [1:0] g);
    @(negedge clk);
    u_mid = u;
    gain = g;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic fall();
    @(negedge clk);
    lrck = 1'b0;
    repeat (3) @(negedge clk);
    lrck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // the push lands on the same edge that registers the pop
  task automatic fall_push(input logic [17:0] u, input logic [1:0] g);
    @(negedge clk);
    lrck = 1'b0;
    repeat (2) @(negedge clk);
    u_mid = u;
    gain = g;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    lrck = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic mute_pulse();
    @(negedge clk);
    mute = 1'b1;
    @(negedge clk);
    mute = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic [2:0] exp);
    chk(name, {o_ovf, o_udf, o_clip}, exp);
  endtask

  int push_pct;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_sample", o_sample, 16'h0000);
    chk("reset_level", o_level, 0);
    chk_flags("reset_flags", 3'b000);
    rst_n = 1'b1;

    push(18'h00400, 0); chk("basic_lvl1", o_level, 1);
    push(18'h3FC00, 0); chk("basic_lvl2", o_level, 2);
    push(18'h1FFFF, 0); chk("basic_lvl3", o_level, 3);
    chk("model_pin_lvl3", q.size(), 3);
    fall(); chk("basic_s1", o_sample, 16'h0100);
    fall(); chk("basic_s2", o_sample, 16'hFF00);
    fall(); chk("basic_s3", o_sample, 16'h7FFF);
    chk("basic_lvl0", o_level, 0);
    chk_flags("basic_flags", 3'b000);

    mute_pulse(); push(18'h10000, 2); fall();
    chk("clip_pos", o_sample, 16'h7FFF); chk("clip_pos_flag", o_clip, 1);
    mute_pulse(); push(18'h20000, 1); fall();
    chk("clip_neg", o_sample, 16'h8000); chk("clip_neg_flag", o_clip, 1);
    mute_pulse(); push(18'h00100, 3); fall();
    chk("gain3", o_sample, 16'h0200); chk("gain3_noclip", o_clip, 0);
    chk("model_pin_gain3", m_sample, 16'h0200);

    mute_pulse();
    for (int i = 0; i < 9; i++) push(18'((i + 1) * 4), 0);
    chk("ovf_level", o_level, 8); chk("ovf_flag", o_ovf, 1);
    for (int i = 0; i < 8; i++) begin
      fall();
      chk("ovf_pop", o_sample, i + 1);
    end
    chk("ovf_drained", o_level, 0);
    fall(); chk("ovf_no9th", o_sample, 16'h0008);

    mute_pulse(); push(18'h048D0, 0); fall();
    chk("hold_pre", o_sample, 16'h1234);
    fall_push(18'h00040, 0);
    chk("hold_sample", o_sample, 16'h1234);
    chk("hold_udf", o_udf, 1);
    chk("hold_level", o_level, 1);

    mute_pulse();
    for (int i = 0; i < 8; i++) push(18'((i + 1) * 'h400), 0);
    fall_push(18'h3FFFC, 0);
    chk("full_level", o_level, 8);
    chk("full_noovf", o_ovf, 0);
    chk("full_oldest", o_sample, 16'h0100);

    mute_pulse(); push(18'h10000, 2); fall(); fall();
    for (int i = 0; i < 9; i++) push(18'((i + 1) * 4), 0);
    repeat (3) fall();
    chk("mute_pre_level", o_level, 5);
    chk_flags("mute_pre_flags", 3'b111);
    @(negedge clk); lrck = 1'b0;
    repeat (2) @(negedge clk);
    mute = 1'b1; valid = 1'b1; u_mid = 18'h00800; gain = 0;
    @(negedge clk); mute = 1'b0;
    chk("mute_level", o_level, 0);
    chk("mute_sample", o_sample, 16'h0000);
    chk_flags("mute_flags", 3'b000);
    @(negedge clk); valid = 1'b0; lrck = 1'b1;
    repeat (3) @(negedge clk);
    chk("mute_no_spurious", o_level, 0);
    push(18'h00800, 0);
    chk("mute_resume", o_level, 1);

    fall(); push(18'h00C00, 0);
    chk("arst_pre", o_sample, 16'h0200);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("arst_sample", o_sample, 16'h0000);
    chk("arst_level", o_level, 0);
    chk_flags("arst_flags", 3'b000);
    #1 rst_n = 1'b1;

    for (int ph = 0; ph < 2; ph++) begin
      push_pct = ph == 0 ? 40 : 8;
      for (int c = 0; c < 1500; c++) begin
        @(negedge clk);
        valid = $urandom_range(0, 99) < push_pct;
        u_mid = 18'($urandom);
        gain = 2'($urandom);
        if ($urandom_range(0, 5) == 0) lrck = ~lrck;
        mute = $urandom_range(0, 199) == 0;
      end
    end
    @(negedge clk);
    valid = 1'b0;
    mute = 1'b0;
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
